// File: rtl/bsg_strobe_event_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_strobe_event_meter: counts events between strobes, reports per window |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module bsg_strobe_event_meter #(
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clear_i,
  input  logic                     strobe_i,
  input  logic                     event_i,
  output logic                     v_o,
  output logic [count_width_p-1:0] count_o,
  output logic                     sat_o,
  input  logic                     yumi_i,
  output logic                     dropped_o
);

  typedef enum logic [0:0] {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } state_e;

  localparam logic [count_width_p-1:0] all_ones_lp = {count_width_p{1'b1}};

  state_e                   state_q, state_d;
  logic [count_width_p-1:0] acc_q, acc_d;
  logic                     acc_sat_q, acc_sat_d;
  logic                     v_q, v_d;
  logic [count_width_p-1:0] count_q, count_d;
  logic                     sat_q, sat_d;
  logic                     dropped_q, dropped_d;

  logic                     acc_full;
  logic [count_width_p-1:0] acc_next;
  logic                     acc_sat_next;
  logic                     close;
  logic                     take;

  // Saturating accumulate including this cycle's event; also the closing value.
  assign acc_full     = (acc_q == all_ones_lp);
  assign acc_next     = (event_i && !acc_full) ? (acc_q + count_width_p'(1)) : acc_q;
  assign acc_sat_next = acc_sat_q | (event_i & acc_full);
  assign close        = (state_q == ARMED) && strobe_i;
  assign take         = yumi_i && v_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    v_d       = v_q;
    count_d   = count_q;
    sat_d     = sat_q;
    dropped_d = dropped_q;

    if (clear_i) begin
      state_d   = UNARMED;
      acc_d     = '0;
      acc_sat_d = 1'b0;
      v_d       = 1'b0;
      count_d   = '0;
      sat_d     = 1'b0;
      dropped_d = 1'b0;
    end else begin
      case (state_q)
        UNARMED: begin
          if (strobe_i) begin
            state_d   = ARMED;
            acc_d     = '0;
            acc_sat_d = 1'b0;
          end
        end
        ARMED: begin
          if (strobe_i) begin
            acc_d     = '0;
            acc_sat_d = 1'b0;
          end else begin
            acc_d     = acc_next;
            acc_sat_d = acc_sat_next;
          end
        end
        default: begin
          state_d = UNARMED;
        end
      endcase

      // A close may reuse the slot only if it is empty or being consumed now.
      if (close) begin
        if (!v_q || take) begin
          v_d     = 1'b1;
          count_d = acc_next;
          sat_d   = acc_sat_next;
        end else begin
          dropped_d = 1'b1;
        end
      end else if (take) begin
        v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= UNARMED;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      v_q       <= 1'b0;
      count_q   <= '0;
      sat_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      v_q       <= v_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      dropped_q <= dropped_d;
    end
  end

  assign v_o       = v_q;
  assign count_o   = count_q;
  assign sat_o     = sat_q;
  assign dropped_o = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_strobe_event_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bsg_strobe_event_meter: directed self-checking bench                   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_bsg_strobe_event_meter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        strobe = 1'b0;
  logic        ev = 1'b0;
  logic        yumi_ready = 1'b0;

  logic        v16, sat16, drop16, yumi16;
  logic [15:0] count16;
  logic        v4, sat4, drop4, yumi4;
  logic [3:0]  count4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Consumer only takes when something is offered, keeping yumi legal.
  assign yumi16 = yumi_ready & v16;
  assign yumi4  = yumi_ready & v4;

  bsg_strobe_event_meter #(.count_width_p(16)) dut16 (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .strobe_i(strobe),
    .event_i(ev), .v_o(v16), .count_o(count16), .sat_o(sat16),
    .yumi_i(yumi16), .dropped_o(drop16)
  );

  bsg_strobe_event_meter #(.count_width_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .strobe_i(strobe),
    .event_i(ev), .v_o(v4), .count_o(count4), .sat_o(sat4),
    .yumi_i(yumi4), .dropped_o(drop4)
  );

  always @(posedge clk) begin
    if (reset_n && yumi16 && !v16) begin
      $display("FAIL yumi_illegal: yumi=1 while v_o=%0b", v16);
      failures++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic gap(input int n);
    strobe = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    strobe = 1'b0; ev = 1'b0; clear = 1'b0; yumi_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (v16 !== 1'b0) begin $display("FAIL reset_v: got %0b want 0", v16); failures++; end
    checks++; if (count16 !== 16'd0) begin $display("FAIL reset_count: got %0d want 0", count16); failures++; end
    checks++; if (sat16 !== 1'b0) begin $display("FAIL reset_sat: got %0b want 0", sat16); failures++; end
    checks++; if (drop16 !== 1'b0) begin $display("FAIL reset_dropped: got %0b want 0", drop16); failures++; end
  endtask

  task automatic test_basic_windows();
    do_reset();
    ev = 1'b1; yumi_ready = 1'b1;
    pulse();
    checks++; if (v16 !== 1'b0) begin $display("FAIL arm_no_report: got v=%0b want 0", v16); failures++; end
    gap(9);
    for (int w = 0; w < 3; w++) begin
      pulse();
      checks++; if (v16 !== 1'b1) begin $display("FAIL basic_v w%0d: got %0b want 1", w, v16); failures++; end
      checks++; if (count16 !== 16'd10) begin $display("FAIL basic_count w%0d: got %0d want 10", w, count16); failures++; end
      checks++; if (sat16 !== 1'b0 || drop16 !== 1'b0) begin $display("FAIL basic_flags w%0d: got sat=%0b drop=%0b want 0/0", w, sat16, drop16); failures++; end
      tick();
      checks++; if (v16 !== 1'b0) begin $display("FAIL basic_v_pulse w%0d: got %0b want 0", w, v16); failures++; end
      gap(8);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ev = 1'b1; yumi_ready = 1'b1;
    pulse();
    gap(39);
    pulse();
    checks++; if (v4 !== 1'b1) begin $display("FAIL sat_v: got %0b want 1", v4); failures++; end
    checks++; if (count4 !== 4'd15) begin $display("FAIL sat_count: got %0d want 15", count4); failures++; end
    checks++; if (sat4 !== 1'b1) begin $display("FAIL sat_flag: got %0b want 1", sat4); failures++; end
    checks++; if (count16 !== 16'd40) begin $display("FAIL wide_count40: got %0d want 40", count16); failures++; end
    gap(7);
    pulse();
    checks++; if (count4 !== 4'd8) begin $display("FAIL post_sat_count: got %0d want 8", count4); failures++; end
    checks++; if (sat4 !== 1'b0) begin $display("FAIL post_sat_flag: got %0b want 0", sat4); failures++; end
    yumi_ready = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    ev = 1'b1; yumi_ready = 1'b0;
    pulse();
    gap(4);
    pulse();
    checks++; if (v16 !== 1'b1 || count16 !== 16'd5) begin $display("FAIL drop_first: got v=%0b count=%0d want 1/5", v16, count16); failures++; end
    checks++; if (drop16 !== 1'b0) begin $display("FAIL drop_early: got %0b want 0", drop16); failures++; end
    gap(4);
    pulse();
    checks++; if (count16 !== 16'd5 || drop16 !== 1'b1) begin $display("FAIL drop_second: got count=%0d drop=%0b want 5/1", count16, drop16); failures++; end
    gap(4);
    pulse();
    checks++; if (v16 !== 1'b1 || count16 !== 16'd5) begin $display("FAIL drop_third: got v=%0b count=%0d want 1/5", v16, count16); failures++; end
    yumi_ready = 1'b1;
    tick();
    yumi_ready = 1'b0;
    checks++; if (v16 !== 1'b0) begin $display("FAIL drop_after_yumi_v: got %0b want 0", v16); failures++; end
    checks++; if (drop16 !== 1'b1) begin $display("FAIL drop_sticky: got %0b want 1", drop16); failures++; end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ev = 1'b1; yumi_ready = 1'b0;
    pulse();
    gap(4);
    pulse();
    checks++; if (count16 !== 16'd5) begin $display("FAIL b2b_first: got %0d want 5", count16); failures++; end
    gap(2);
    yumi_ready = 1'b1;
    pulse();
    yumi_ready = 1'b0;
    checks++; if (v16 !== 1'b1) begin $display("FAIL b2b_v: got %0b want 1", v16); failures++; end
    checks++; if (count16 !== 16'd3) begin $display("FAIL b2b_count: got %0d want 3", count16); failures++; end
    checks++; if (drop16 !== 1'b0) begin $display("FAIL b2b_dropped: got %0b want 0", drop16); failures++; end
  endtask

  task automatic test_coincident();
    do_reset();
    yumi_ready = 1'b1;
    ev = 1'b1; pulse(); ev = 1'b0;
    for (int w = 0; w < 3; w++) begin
      gap(5);
      ev = 1'b1; pulse(); ev = 1'b0;
      checks++; if (v16 !== 1'b1 || count16 !== 16'd1) begin $display("FAIL coinc w%0d: got v=%0b count=%0d want 1/1", w, v16, count16); failures++; end
    end
    for (int i = 0; i < 6; i++) begin
      strobe = 1'b1;
      ev = (i % 2 == 0);
      tick();
      checks++; if (v16 !== 1'b1 || count16 !== ((i % 2 == 0) ? 16'd1 : 16'd0)) begin
        $display("FAIL period1 i%0d: got v=%0b count=%0d want 1/%0d", i, v16, count16, (i % 2 == 0) ? 1 : 0); failures++;
      end
    end
    strobe = 1'b0; ev = 1'b0; yumi_ready = 1'b0;
  endtask

  task automatic test_reset_clear_midwindow();
    do_reset();
    ev = 1'b1; yumi_ready = 1'b0;
    pulse();
    gap(4);
    pulse();
    gap(2);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (v16 !== 1'b0 || count16 !== 16'd0 || sat16 !== 1'b0 || drop16 !== 1'b0) begin
      $display("FAIL async_reset: got v=%0b count=%0d sat=%0b drop=%0b want all 0", v16, count16, sat16, drop16); failures++;
    end
    reset_n = 1'b1;
    tick();
    pulse();
    gap(4);
    checks++; if (v16 !== 1'b0) begin $display("FAIL rearm_no_report: got %0b want 0", v16); failures++; end
    pulse();
    checks++; if (v16 !== 1'b1 || count16 !== 16'd5) begin $display("FAIL rearm_first: got v=%0b count=%0d want 1/5", v16, count16); failures++; end
    gap(4);
    pulse();
    checks++; if (drop16 !== 1'b1) begin $display("FAIL pre_clear_drop: got %0b want 1", drop16); failures++; end
    gap(2);
    clear = 1'b1; strobe = 1'b1; yumi_ready = 1'b1;
    tick();
    clear = 1'b0; strobe = 1'b0; yumi_ready = 1'b0;
    checks++; if (v16 !== 1'b0 || count16 !== 16'd0 || sat16 !== 1'b0 || drop16 !== 1'b0) begin
      $display("FAIL clear_state: got v=%0b count=%0d sat=%0b drop=%0b want all 0", v16, count16, sat16, drop16); failures++;
    end
    pulse();
    gap(4);
    checks++; if (v16 !== 1'b0) begin $display("FAIL clear_rearm_no_report: got %0b want 0", v16); failures++; end
    pulse();
    checks++; if (v16 !== 1'b1 || count16 !== 16'd5) begin $display("FAIL clear_first: got v=%0b count=%0d want 1/5", v16, count16); failures++; end
  endtask

  initial begin
    test_reset();
    test_basic_windows();
    test_saturation();
    test_drop();
    test_back_to_back();
    test_coincident();
    test_reset_clear_midwindow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bsg_strobe_event_meter.md
Name: bsg_strobe_event_meter

Overview:
- Sits directly downstream of bsg_strobe. Consumes its one-cycle strobe as a measurement-window boundary.
- Counts event pulses between consecutive strobes and latches each completed window's count into an output register with valid/yumi handshake.
- Used as a rate meter (e.g. clock-ratio or traffic measurement) with strobe period set by the bsg_strobe init value.

Parameters:
count_width_p, 16, width of event accumulator and reported count; saturates at 2^count_width_p-1

Ports:
clk_i  input  1  clock
reset_n_i  input  1  asynchronous, active-low reset
clear_i  input  1  synchronous clear of all state; priority over everything else
strobe_i  input  1  window boundary pulse (bsg_strobe strobe_r_o)
event_i  input  1  event to count, one per cycle max
v_o  output  1  completed window count valid
count_o  output  count_width_p  count of completed window
sat_o  output  1  that window saturated (qualified by v_o)
yumi_i  input  1  consumer takes count; legal only when v_o=1
dropped_o  output  1  sticky: a completed window was discarded because output was full

Behaviour:
- Reset (reset_n_i=0, async): acc_r=0, state=UNARMED, v_o=0, count_o=0, sat_o=0, dropped_o=0.
- Counting state machine:
  - UNARMED: events ignored. strobe_i -> ARMED, acc_r<=0. The partial window after reset/clear is never reported.
  - ARMED: each cycle acc_r <= acc_r + event_i, saturating at all-ones; sat_r set if an increment is attempted at all-ones.
  - ARMED with strobe_i: window closes.
    - Closing value = sat(acc_r + event_i), so an event coincident with strobe belongs to the closing window.
    - acc_r<=0 and sat_r<=0 next cycle; stays ARMED.
- Output register, EMPTY/FULL:
  - Window closes at cycle t -> v_o=1 at t+1 with count_o/sat_o. Latency is 1 cycle.
  - FULL, no yumi_i: v_o, count_o and sat_o hold stable.
  - yumi_i in FULL with no close that cycle -> EMPTY next cycle. count_o holds its last value (don't-care).
  - Close and yumi_i in the same cycle -> new value loaded, v_o stays 1, no drop.
  - Close while FULL without yumi_i -> new value discarded, old value retained, dropped_o<=1. dropped_o is sticky until clear_i or reset.
  - Close while EMPTY -> loaded, FULL.
- clear_i=1: same state as reset on the next edge. strobe_i, event_i and yumi_i are ignored that cycle.
- Strobe period 1 (strobe_i every cycle): each window = event_i of that cycle, so count_o is 0 or 1. Must be supported.
- yumi_i with v_o=0: illegal. RTL ignores it. A bench assertion flags it.
- Width arithmetic: acc_r is count_width_p bits. Saturation compare against all-ones, no wrap-around.

Test Plan:
1. Reset, then strobe every 10 cycles, event_i=1 continuously, yumi_i tied 1 -> first strobe only arms; each later window gives v_o for 1 cycle, count_o=10, sat_o=0, dropped_o=0.
2. count_width_p=4, strobe period 40, event_i=1 -> count_o=15, sat_o=1. Next window with period 8 -> count_o=8, sat_o=0.
3. yumi_i=0, three windows of 5 events each, then yumi_i pulse -> count_o=5 retained from first window, dropped_o=1 after second close. After yumi, v_o=0 and dropped_o stays 1.
4. yumi_i asserted exactly on a strobe cycle with v_o=1 -> v_o stays 1, count_o takes the new window value, dropped_o=0.
5. Event only on strobe cycles, period 6 -> each count_o=1 (coincident event counted in the closing window, none leaked into the next). Period 1 with event_i alternating 1/0 -> count_o alternates 1/0.
6. Async reset_n_i low mid-window with v_o=1, and separately clear_i -> all outputs 0 immediately (reset) or next edge (clear). Next strobe only arms; first report comes one full window later.
